// File: rtl/conv1d_feeder.sv
// Sequencer for a 3-tap MAC: clears it, loads three weights, streams features and
// registers each full-window MAC output into a valid/ready result stream.
// Optional build macro: CONV1D_FEEDER_RELU_EN clamps negative results to zero.
module conv1d_feeder #(
    parameter int DATA_BIT = 16,
    parameter int LEN_BIT  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_BIT-1:0]    feat_len,
    input  logic                  w_valid,
    input  logic [DATA_BIT-1:0]   w_data,
    output logic                  w_ready,
    input  logic                  f_valid,
    input  logic [DATA_BIT-1:0]   f_data,
    output logic                  f_ready,
    output logic                  mac_clear,
    output logic                  mac_w_w,
    output logic [DATA_BIT-1:0]   mac_w_in,
    output logic                  mac_if_w,
    output logic [DATA_BIT-1:0]   mac_if_in,
    input  logic [2*DATA_BIT+1:0] mac_out,
    output logic                  res_valid,
    output logic [2*DATA_BIT+1:0] res_data,
    input  logic                  res_ready,
    output logic                  busy,
    output logic                  done
);

    // state  | meaning
    // IDLE   | waiting for start with feat_len >= 3
    // CLR    | one-cycle MAC clear
    // LOAD_W | accepting three weights
    // FEAT   | streaming features, emitting N-2 window results
    typedef enum logic [1:0] {IDLE, CLR, LOAD_W, FEAT} state_t;

    state_t               state;
    state_t               state_nx;
    logic [LEN_BIT-1:0]   n_q;
    logic [LEN_BIT-1:0]   fcnt;
    logic [1:0]           wcnt;
    logic                 pend;
    logic                 w_hs;
    logic                 f_hs;
    logic                 r_hs;
    logic                 start_ok;
    logic                 feat_end;

    assign w_hs     = mac_w_w;
    assign f_hs     = mac_if_w;
    assign r_hs     = res_valid && res_ready;
    assign start_ok = start && (feat_len >= LEN_BIT'(3));
    // The last result is the only one that can be valid once every feature is in.
    assign feat_end = (state == FEAT) && (fcnt == n_q) && !pend && r_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = CLR;
            CLR:     state_nx = LOAD_W;
            LOAD_W:  if (w_hs && (wcnt == 2'd2)) state_nx = FEAT;
            FEAT:    if (feat_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_ready   = 1'b0;
        f_ready   = 1'b0;
        mac_clear = 1'b0;
        busy      = (state != IDLE);
        case (state)
            CLR:     mac_clear = 1'b1;
            LOAD_W:  w_ready = 1'b1;
            FEAT:    f_ready = !pend && (!res_valid || res_ready) && (fcnt != n_q);
            default: ;
        endcase
        mac_w_w   = w_ready && w_valid;
        mac_w_in  = mac_w_w ? w_data : '0;
        mac_if_w  = f_ready && f_valid;
        mac_if_in = mac_if_w ? f_data : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q       <= '0;
            fcnt      <= '0;
            wcnt      <= '0;
            pend      <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= feat_end;
            if ((state == IDLE) && start_ok) n_q <= feat_len;
            if (state == CLR) begin
                wcnt <= '0;
                fcnt <= '0;
            end
            if (w_hs) wcnt <= wcnt + 2'd1;
            if (f_hs) fcnt <= fcnt + LEN_BIT'(1);
            // MAC output is valid the cycle after the feature that fills a window.
            pend <= f_hs && (fcnt >= LEN_BIT'(2));
            if (pend) begin
                res_valid <= 1'b1;
`ifdef CONV1D_FEEDER_RELU_EN
                res_data  <= mac_out[2*DATA_BIT+1] ? '0 : mac_out;
`else
                res_data  <= mac_out;
`endif
            end else if (r_hs) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule
